// File: rtl/ldst_pipe_pkg.sv
// Shared types, codes and helpers for the load/store pipeline stage.
package ldst_pipe_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // FSM state encodings
  typedef enum logic [1:0] {
    L_PARAM_LDST_IDLE = 2'd0,
    L_PARAM_LDST_REQ  = 2'd1,
    L_PARAM_LDST_WAIT = 2'd2,
    L_PARAM_LDST_DONE = 2'd3
  } ldst_state_t;

  // Access order codes
  localparam logic [1:0] ORDER_BYTE    = 2'd0;
  localparam logic [1:0] ORDER_HALF    = 2'd1;
  localparam logic [1:0] ORDER_WORD    = 2'd2;
  localparam logic [1:0] ORDER_ILLEGAL = 2'd3;

  // Load result width codes
  localparam logic [1:0] MASK_8      = 2'd0;
  localparam logic [1:0] MASK_16     = 2'd1;
  localparam logic [1:0] MASK_32_ALT = 2'd2;
  localparam logic [1:0] MASK_32     = 2'd3;

  // Captured command, already in memory-port form
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   byteena;
    logic [1:0]        shift;
    logic [1:0]        mask;
  } ldst_cmd_t;

  // Misalignment or illegal order detection
  function automatic logic ldst_fault(input logic [1:0] order, input logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    case (order)
      ORDER_HALF:    f = addr_lo[0];
      ORDER_WORD:    f = |addr_lo;
      ORDER_ILLEGAL: f = 1'b1;
      default:       f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ldst_align.sv
// Byte-enable generation, store lane replication and load extract/zero-extend.
module ldst_align
  import ldst_pipe_pkg::*;
(
  input  logic [1:0]        order,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_word,
  input  logic [1:0]        ld_shift,
  input  logic [1:0]        ld_mask,
  output logic [BE_W-1:0]   byteena_c,
  output logic [DATA_W-1:0] st_lanes_c,
  output logic [DATA_W-1:0] ld_result_c
);

  logic [DATA_W-1:0] shifted_c;

  // Big-endian lanes: bit3 enables bits[31:24], i.e. address offset 0
  always_comb begin
    byteena_c  = '0;
    st_lanes_c = st_data;
    case (order)
      ORDER_BYTE: begin
        byteena_c  = BE_W'(4'b1000 >> addr_lo);
        st_lanes_c = {4{st_data[7:0]}};
      end
      ORDER_HALF: begin
        byteena_c  = addr_lo[1] ? BE_W'(4'b0011) : BE_W'(4'b1100);
        st_lanes_c = {2{st_data[15:0]}};
      end
      ORDER_WORD: begin
        byteena_c  = BE_W'(4'b1111);
        st_lanes_c = st_data;
      end
      default: begin
        byteena_c  = '0;
        st_lanes_c = st_data;
      end
    endcase
  end

  // Right-shift the returned word by whole bytes, then zero-extend to width
  always_comb begin
    shifted_c   = ld_word >> {ld_shift, 3'b000};
    ld_result_c = shifted_c;
    case (ld_mask)
      MASK_8:      ld_result_c = {24'h000000, shifted_c[7:0]};
      MASK_16:     ld_result_c = {16'h0000, shifted_c[15:0]};
      MASK_32_ALT: ld_result_c = shifted_c;
      MASK_32:     ld_result_c = shifted_c;
      default:     ld_result_c = shifted_c;
    endcase
  end

endmodule

// File: rtl/ldst_pipe.sv
// Single-outstanding load/store unit between execute and writeback.
module ldst_pipe
  import ldst_pipe_pkg::*;
(
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iFLUSH,
  input  logic              iPREV_VALID,
  output logic              oPREV_BUSY,
  input  logic              iPREV_RW,
  input  logic [ADDR_W-1:0] iPREV_ADDR,
  input  logic [DATA_W-1:0] iPREV_DATA,
  input  logic [1:0]        iPREV_ORDER,
  input  logic [1:0]        iPREV_LOAD_SHIFT,
  input  logic [1:0]        iPREV_LOAD_MASK,
  output logic              oDATAIO_REQ,
  input  logic              iDATAIO_BUSY,
  output logic              oDATAIO_RW,
  output logic [ADDR_W-1:0] oDATAIO_ADDR,
  output logic [DATA_W-1:0] oDATAIO_DATA,
  output logic [BE_W-1:0]   oDATAIO_BYTEENA,
  input  logic              iDATAIO_VALID,
  input  logic [DATA_W-1:0] iDATAIO_DATA,
  output logic              oNEXT_VALID,
  input  logic              iNEXT_BUSY,
  output logic [DATA_W-1:0] oNEXT_DATA,
  output logic              oNEXT_FAULT
);

  ldst_state_t       state_q, state_d;
  logic              drop_q, drop_d;
  logic              capture_c, load_done_c, fault_c;
  ldst_cmd_t         cmd_q;
  logic              fault_q;
  logic [DATA_W-1:0] result_q;
  logic              busy_q, req_q, valid_q;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] lanes_c, ld_result_c;

  ldst_align u_align (
    .order       (iPREV_ORDER),
    .addr_lo     (iPREV_ADDR[1:0]),
    .st_data     (iPREV_DATA),
    .ld_word     (iDATAIO_DATA),
    .ld_shift    (cmd_q.shift),
    .ld_mask     (cmd_q.mask),
    .byteena_c   (be_c),
    .st_lanes_c  (lanes_c),
    .ld_result_c (ld_result_c)
  );

  assign fault_c = ldst_fault(iPREV_ORDER, iPREV_ADDR[1:0]);

  // Next-state logic; a flush after the memory accepted a load waits out its data
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    capture_c   = 1'b0;
    load_done_c = 1'b0;
    case (state_q)
      L_PARAM_LDST_IDLE: begin
        drop_d = 1'b0;
        if (!iFLUSH && iPREV_VALID) begin
          capture_c = 1'b1;
          state_d   = fault_c ? L_PARAM_LDST_DONE : L_PARAM_LDST_REQ;
        end
      end
      L_PARAM_LDST_REQ: begin
        if (!iDATAIO_BUSY) begin
          if (cmd_q.rw) begin
            state_d = iFLUSH ? L_PARAM_LDST_IDLE : L_PARAM_LDST_DONE;
          end else begin
            state_d = L_PARAM_LDST_WAIT;
            drop_d  = iFLUSH;
          end
        end else if (iFLUSH) begin
          state_d = L_PARAM_LDST_IDLE;
        end
      end
      L_PARAM_LDST_WAIT: begin
        if (iDATAIO_VALID) begin
          drop_d      = 1'b0;
          load_done_c = !(drop_q || iFLUSH);
          state_d     = (drop_q || iFLUSH) ? L_PARAM_LDST_IDLE : L_PARAM_LDST_DONE;
        end else if (iFLUSH) begin
          drop_d = 1'b1;
        end
      end
      L_PARAM_LDST_DONE: begin
        if (iFLUSH || !iNEXT_BUSY) begin
          state_d = L_PARAM_LDST_IDLE;
        end
      end
      default: begin
        state_d = L_PARAM_LDST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // State register and registered handshake outputs derived from next state
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= L_PARAM_LDST_IDLE;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      busy_q  <= (state_d != L_PARAM_LDST_IDLE);
      req_q   <= (state_d == L_PARAM_LDST_REQ);
      valid_q <= (state_d == L_PARAM_LDST_DONE);
    end
  end

  // Command capture and load result register
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      cmd_q    <= '0;
      fault_q  <= 1'b0;
      result_q <= '0;
    end else if (capture_c) begin
      cmd_q.rw      <= iPREV_RW;
      cmd_q.addr    <= iPREV_ADDR;
      cmd_q.data    <= lanes_c;
      cmd_q.byteena <= be_c;
      cmd_q.shift   <= iPREV_LOAD_SHIFT;
      cmd_q.mask    <= iPREV_LOAD_MASK;
      fault_q       <= fault_c;
      result_q      <= '0;
    end else if (load_done_c) begin
      result_q <= ld_result_c;
    end
  end

  assign oPREV_BUSY      = busy_q;
  assign oDATAIO_REQ     = req_q;
  assign oDATAIO_RW      = cmd_q.rw;
  assign oDATAIO_ADDR    = cmd_q.addr;
  assign oDATAIO_DATA    = cmd_q.data;
  assign oDATAIO_BYTEENA = cmd_q.byteena;
  assign oNEXT_VALID     = valid_q;
  assign oNEXT_DATA      = result_q;
  assign oNEXT_FAULT     = fault_q;

endmodule

// File: tb/tb_ldst_pipe.sv
// Self-checking bench for ldst_pipe: directed scenarios plus randomized traffic.
module tb_ldst_pipe;

  logic        iCLOCK = 1'b0;
  logic        iRESET, iFLUSH, iPREV_VALID, iPREV_RW;
  logic [31:0] iPREV_ADDR, iPREV_DATA;
  logic [1:0]  iPREV_ORDER, iPREV_LOAD_SHIFT, iPREV_LOAD_MASK;
  logic        iDATAIO_BUSY, iDATAIO_VALID, iNEXT_BUSY;
  logic [31:0] iDATAIO_DATA;
  logic        oPREV_BUSY, oDATAIO_REQ, oDATAIO_RW, oNEXT_VALID, oNEXT_FAULT;
  logic [31:0] oDATAIO_ADDR, oDATAIO_DATA, oNEXT_DATA;
  logic [3:0]  oDATAIO_BYTEENA;

  int errors = 0;
  int checks = 0;

  ldst_pipe dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iFLUSH(iFLUSH),
    .iPREV_VALID(iPREV_VALID), .oPREV_BUSY(oPREV_BUSY), .iPREV_RW(iPREV_RW),
    .iPREV_ADDR(iPREV_ADDR), .iPREV_DATA(iPREV_DATA), .iPREV_ORDER(iPREV_ORDER),
    .iPREV_LOAD_SHIFT(iPREV_LOAD_SHIFT), .iPREV_LOAD_MASK(iPREV_LOAD_MASK),
    .oDATAIO_REQ(oDATAIO_REQ), .iDATAIO_BUSY(iDATAIO_BUSY), .oDATAIO_RW(oDATAIO_RW),
    .oDATAIO_ADDR(oDATAIO_ADDR), .oDATAIO_DATA(oDATAIO_DATA),
    .oDATAIO_BYTEENA(oDATAIO_BYTEENA), .iDATAIO_VALID(iDATAIO_VALID),
    .iDATAIO_DATA(iDATAIO_DATA), .oNEXT_VALID(oNEXT_VALID), .iNEXT_BUSY(iNEXT_BUSY),
    .oNEXT_DATA(oNEXT_DATA), .oNEXT_FAULT(oNEXT_FAULT)
  );

  always #5 iCLOCK = ~iCLOCK;

  // ---------------- reference model ----------------
  function automatic logic m_fault(input logic [1:0] order, input logic [31:0] addr);
    int size;
    if (order == 2'd3) return 1'b1;
    size = 1 << order;
    return (int'(addr[1:0]) % size) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] order, input logic [31:0] addr);
    int size;
    int off;
    logic [3:0] be;
    size = 1 << order;
    off  = int'(addr[1:0]);
    be   = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + size) be[3-i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_lanes(input logic [1:0] order, input logic [31:0] d);
    int size;
    logic [31:0] r;
    size = 1 << order;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_result(input logic [31:0] w, input logic [1:0] shift,
                                           input logic [1:0] mask);
    logic [31:0] msk;
    msk = (mask == 2'd0) ? 32'h0000_00FF : (mask == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (w >> (8 * int'(shift))) & msk;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic clear_inputs();
    iFLUSH = 0; iPREV_VALID = 0; iPREV_RW = 0; iPREV_ADDR = 0; iPREV_DATA = 0;
    iPREV_ORDER = 0; iPREV_LOAD_SHIFT = 0; iPREV_LOAD_MASK = 0;
    iDATAIO_BUSY = 0; iDATAIO_VALID = 0; iDATAIO_DATA = 0; iNEXT_BUSY = 0;
  endtask

  task automatic present(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] order, input logic [1:0] shift, input logic [1:0] mask);
    iPREV_VALID = 1; iPREV_RW = rw; iPREV_ADDR = addr; iPREV_DATA = data;
    iPREV_ORDER = order; iPREV_LOAD_SHIFT = shift; iPREV_LOAD_MASK = mask;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    iRESET = 1;
    step(); step();
    checks++;
    if ({oPREV_BUSY, oDATAIO_REQ, oDATAIO_RW, oNEXT_VALID, oNEXT_FAULT} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000",
        {oPREV_BUSY, oDATAIO_REQ, oDATAIO_RW, oNEXT_VALID, oNEXT_FAULT});
    end
    checks++;
    if ({oDATAIO_ADDR, oDATAIO_DATA, oDATAIO_BYTEENA, oNEXT_DATA} !== 100'b0) begin
      errors++; $display("FAIL reset_data addr=%h data=%h be=%b nd=%h",
        oDATAIO_ADDR, oDATAIO_DATA, oDATAIO_BYTEENA, oNEXT_DATA);
    end
    iRESET = 0;
    step();
  endtask

  task automatic test_load8();
    present(0, 32'h1003, 32'h0, 2'd0, 2'd0, 2'd0);
    step(); iPREV_VALID = 0;
    checks++;
    if ({oDATAIO_REQ, oPREV_BUSY, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_BYTEENA} !==
        {1'b1, 1'b1, 1'b0, 32'h1003, 4'b0001}) begin
      errors++; $display("FAIL ld8_req req=%b busy=%b rw=%b addr=%h be=%b exp 1 1 0 00001003 0001",
        oDATAIO_REQ, oPREV_BUSY, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_BYTEENA);
    end
    step();
    checks++;
    if (oDATAIO_REQ !== 1'b0 || oNEXT_VALID !== 1'b0) begin
      errors++; $display("FAIL ld8_wait req=%b nv=%b exp 0 0", oDATAIO_REQ, oNEXT_VALID);
    end
    iDATAIO_VALID = 1; iDATAIO_DATA = 32'hAABBCCDD;
    step(); iDATAIO_VALID = 0;
    checks++;
    if ({oNEXT_VALID, oNEXT_FAULT, oNEXT_DATA} !== {1'b1, 1'b0, 32'h0000_00DD}) begin
      errors++; $display("FAIL ld8_result nv=%b f=%b d=%h exp 1 0 000000dd",
        oNEXT_VALID, oNEXT_FAULT, oNEXT_DATA);
    end
    step();
    checks++;
    if (oNEXT_VALID !== 1'b0 || oPREV_BUSY !== 1'b0) begin
      errors++; $display("FAIL ld8_retire nv=%b busy=%b exp 0 0", oNEXT_VALID, oPREV_BUSY);
    end
  endtask

  task automatic test_ld16_busy();
    present(0, 32'h2000, 32'h0, 2'd1, 2'd2, 2'd1);
    iDATAIO_BUSY = 1;
    step(); iPREV_VALID = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({oDATAIO_REQ, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_BYTEENA} !==
          {1'b1, 1'b0, 32'h2000, 4'b1100}) begin
        errors++; $display("FAIL ld16_hold[%0d] req=%b rw=%b addr=%h be=%b exp 1 0 00002000 1100",
          i, oDATAIO_REQ, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_BYTEENA);
      end
      if (i == 3) iDATAIO_BUSY = 0;
      step();
    end
    checks++;
    if (oDATAIO_REQ !== 1'b0) begin
      errors++; $display("FAIL ld16_req_drop req=%b exp 0", oDATAIO_REQ);
    end
    iDATAIO_VALID = 1; iDATAIO_DATA = 32'h12345678;
    step(); iDATAIO_VALID = 0;
    checks++;
    if ({oNEXT_VALID, oNEXT_DATA} !== {1'b1, 32'h0000_1234}) begin
      errors++; $display("FAIL ld16_result nv=%b d=%h exp 1 00001234", oNEXT_VALID, oNEXT_DATA);
    end
    step();
  endtask

  task automatic test_store8();
    present(1, 32'h3002, 32'h0000_00EE, 2'd0, 2'd0, 2'd0);
    step(); iPREV_VALID = 0;
    checks++;
    if ({oDATAIO_REQ, oDATAIO_RW, oDATAIO_BYTEENA, oDATAIO_DATA} !==
        {1'b1, 1'b1, 4'b0010, 32'hEEEE_EEEE}) begin
      errors++; $display("FAIL st8_req req=%b rw=%b be=%b d=%h exp 1 1 0010 eeeeeeee",
        oDATAIO_REQ, oDATAIO_RW, oDATAIO_BYTEENA, oDATAIO_DATA);
    end
    step();
    checks++;
    if ({oNEXT_VALID, oNEXT_FAULT, oNEXT_DATA, oDATAIO_REQ} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL st8_done nv=%b f=%b d=%h req=%b exp 1 0 00000000 0",
        oNEXT_VALID, oNEXT_FAULT, oNEXT_DATA, oDATAIO_REQ);
    end
    step();
  endtask

  task automatic test_fault();
    present(0, 32'h4002, 32'h0, 2'd2, 2'd0, 2'd3);
    step(); iPREV_VALID = 0;
    checks++;
    if ({oDATAIO_REQ, oNEXT_VALID, oNEXT_FAULT} !== 3'b011) begin
      errors++; $display("FAIL fault_ld32 req=%b nv=%b f=%b exp 0 1 1",
        oDATAIO_REQ, oNEXT_VALID, oNEXT_FAULT);
    end
    step();
    checks++;
    if (oNEXT_VALID !== 1'b0 || oPREV_BUSY !== 1'b0) begin
      errors++; $display("FAIL fault_retire nv=%b busy=%b exp 0 0", oNEXT_VALID, oPREV_BUSY);
    end
  endtask

  task automatic test_flush_wait();
    present(0, 32'h5000, 32'h0, 2'd2, 2'd0, 2'd3);
    step(); iPREV_VALID = 0;
    step();
    iFLUSH = 1;
    step(); iFLUSH = 0;
    checks++;
    if (oPREV_BUSY !== 1'b1 || oNEXT_VALID !== 1'b0) begin
      errors++; $display("FAIL flush_wait_a busy=%b nv=%b exp 1 0", oPREV_BUSY, oNEXT_VALID);
    end
    step();
    checks++;
    if (oPREV_BUSY !== 1'b1 || oNEXT_VALID !== 1'b0) begin
      errors++; $display("FAIL flush_wait_b busy=%b nv=%b exp 1 0", oPREV_BUSY, oNEXT_VALID);
    end
    iDATAIO_VALID = 1; iDATAIO_DATA = 32'hDEADBEEF;
    step(); iDATAIO_VALID = 0;
    checks++;
    if (oPREV_BUSY !== 1'b0 || oNEXT_VALID !== 1'b0) begin
      errors++; $display("FAIL flush_absorb busy=%b nv=%b exp 0 0", oPREV_BUSY, oNEXT_VALID);
    end
    step();
  endtask

  task automatic test_flush_req();
    present(0, 32'h6000, 32'h0, 2'd2, 2'd0, 2'd3);
    iDATAIO_BUSY = 1;
    step(); iPREV_VALID = 0;
    iFLUSH = 1;
    step(); iFLUSH = 0; iDATAIO_BUSY = 0;
    checks++;
    if ({oDATAIO_REQ, oPREV_BUSY, oNEXT_VALID} !== 3'b000) begin
      errors++; $display("FAIL flush_req req=%b busy=%b nv=%b exp 0 0 0",
        oDATAIO_REQ, oPREV_BUSY, oNEXT_VALID);
    end
  endtask

  task automatic test_next_busy();
    present(0, 32'h7000, 32'h0, 2'd2, 2'd1, 2'd3);
    iNEXT_BUSY = 1;
    step(); iPREV_VALID = 0;
    step();
    iDATAIO_VALID = 1; iDATAIO_DATA = 32'hCAFEF00D;
    step(); iDATAIO_VALID = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({oNEXT_VALID, oNEXT_DATA} !== {1'b1, 32'h00CA_FEF0}) begin
        errors++; $display("FAIL next_busy_hold[%0d] nv=%b d=%h exp 1 00cafef0",
          i, oNEXT_VALID, oNEXT_DATA);
      end
      if (i == 4) iNEXT_BUSY = 0;
      step();
    end
    checks++;
    if (oNEXT_VALID !== 1'b0) begin
      errors++; $display("FAIL next_busy_release nv=%b exp 0", oNEXT_VALID);
    end
  endtask

  task automatic test_reset_mid();
    present(1, 32'h8000, 32'h11223344, 2'd2, 2'd0, 2'd3);
    iDATAIO_BUSY = 1;
    step(); iPREV_VALID = 0;
    #2 iRESET = 1;
    #1;
    checks++;
    if ({oPREV_BUSY, oDATAIO_REQ, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_DATA, oDATAIO_BYTEENA,
         oNEXT_VALID, oNEXT_DATA, oNEXT_FAULT} !== 105'b0) begin
      errors++; $display("FAIL reset_mid req=%b busy=%b addr=%h data=%h be=%b exp all 0",
        oDATAIO_REQ, oPREV_BUSY, oDATAIO_ADDR, oDATAIO_DATA, oDATAIO_BYTEENA);
    end
    step();
    iRESET = 0; iDATAIO_BUSY = 0;
    iDATAIO_VALID = 1; iDATAIO_DATA = 32'h55555555;
    step(); iDATAIO_VALID = 0;
    step();
    checks++;
    if (oNEXT_VALID !== 1'b0 || oPREV_BUSY !== 1'b0) begin
      errors++; $display("FAIL stale_valid nv=%b busy=%b exp 0 0", oNEXT_VALID, oPREV_BUSY);
    end
  endtask

  task automatic test_random();
    logic        rw;
    logic [31:0] addr, data, rdata;
    logic [1:0]  order, shift, mask;
    int          nb, lat, hold, cyc;
    logic        accepted;
    for (int n = 0; n < 80; n++) begin
      rw = 1'($urandom); addr = $urandom; data = $urandom;
      order = 2'($urandom_range(0, 3)); shift = 2'($urandom); mask = 2'($urandom);
      present(rw, addr, data, order, shift, mask);
      step(); iPREV_VALID = 0;
      rdata = 32'h0;
      if (!m_fault(order, addr)) begin
        nb = $urandom_range(0, 2); accepted = 0; cyc = 0;
        while (!accepted && cyc < 20) begin
          checks++;
          if ({oDATAIO_REQ, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_BYTEENA} !==
              {1'b1, rw, addr, m_be(order, addr)}) begin
            errors++; $display("FAIL rnd_req[%0d] req=%b rw=%b addr=%h be=%b exp 1 %b %h %b",
              n, oDATAIO_REQ, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_BYTEENA, rw, addr, m_be(order, addr));
          end
          if (rw) begin
            checks++;
            if (oDATAIO_DATA !== m_lanes(order, data)) begin
              errors++; $display("FAIL rnd_stdata[%0d] got=%h exp=%h",
                n, oDATAIO_DATA, m_lanes(order, data));
            end
          end
          iDATAIO_BUSY = (nb > 0);
          if (nb > 0) nb--; else accepted = 1;
          step(); cyc++;
        end
        iDATAIO_BUSY = 0;
        if (!rw) begin
          lat = $urandom_range(0, 2);
          for (int k = 0; k < lat; k++) begin
            checks++;
            if (oNEXT_VALID !== 1'b0 || oDATAIO_REQ !== 1'b0) begin
              errors++; $display("FAIL rnd_wait[%0d] nv=%b req=%b exp 0 0", n, oNEXT_VALID, oDATAIO_REQ);
            end
            step();
          end
          rdata = $urandom;
          iDATAIO_VALID = 1; iDATAIO_DATA = rdata;
          step(); iDATAIO_VALID = 0;
        end
      end
      checks++;
      if ({oNEXT_VALID, oNEXT_FAULT, oNEXT_DATA} !==
          {1'b1, m_fault(order, addr),
           (m_fault(order, addr) || rw) ? 32'h0 : m_result(rdata, shift, mask)}) begin
        errors++; $display("FAIL rnd_result[%0d] nv=%b f=%b d=%h exp 1 %b %h", n,
          oNEXT_VALID, oNEXT_FAULT, oNEXT_DATA, m_fault(order, addr),
          (m_fault(order, addr) || rw) ? 32'h0 : m_result(rdata, shift, mask));
      end
      hold = $urandom_range(0, 2);
      iNEXT_BUSY = (hold > 0);
      for (int h = 0; h < hold; h++) begin
        step();
        if (h == hold - 1) iNEXT_BUSY = 0;
        checks++;
        if (oNEXT_VALID !== 1'b1) begin
          errors++; $display("FAIL rnd_hold[%0d] nv=%b exp 1", n, oNEXT_VALID);
        end
      end
      iNEXT_BUSY = 0;
      step();
      checks++;
      if (oNEXT_VALID !== 1'b0 || oPREV_BUSY !== 1'b0) begin
        errors++; $display("FAIL rnd_retire[%0d] nv=%b busy=%b exp 0 0", n, oNEXT_VALID, oPREV_BUSY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load8();
    test_ld16_busy();
    test_store8();
    test_fault();
    test_flush_wait();
    test_flush_req();
    test_next_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
